// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      MEM_B,
      MEM_H,
      MEM_W,
      MEM_D
   } mem_size_e;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_RESP
   } dmem_rsp_state_e;

   localparam int MAX_LATENCY = 15;

   // Number of bytes moved by an access of the given size.
   function automatic int size_bytes(input mem_size_e sz);
      return 1 << int'(sz);
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit.sv
// Byte-lane steering for stores and sign/zero extension for loads.
module dmem_lane_unit
   import dmem_responder_pkg::*;
#(
   parameter  int XLEN = 64,
   localparam int NB   = XLEN / 8,
   localparam int OFFW = $clog2(NB)
) (
   input  logic [OFFW-1:0] lane,
   input  mem_size_e       size,
   input  logic            sext,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [NB-1:0]   strb,
   output logic [XLEN-1:0] wrep,
   output logic [XLEN-1:0] rext,
   output logic            misal
);

   int              nb;
   int              msb;
   logic [XLEN-1:0] sh;
   logic            fill;

   // Strobes, replicated store data, aligned/extended load data.
   always_comb begin
      nb    = size_bytes(size);
      msb   = (8 * nb > XLEN) ? XLEN - 1 : 8 * nb - 1;
      misal = ((int'(lane) & (nb - 1)) != 0);
      for (int i = 0; i < NB; i++) begin
         strb[i]        = (i >= int'(lane)) && (i < int'(lane) + nb);
         wrep[8*i +: 8] = wdata[8*(i & (nb - 1)) +: 8];
      end
      sh   = rword >> (8 * int'(lane));
      fill = sext & sh[msb];
      for (int b = 0; b < XLEN; b++) begin
         rext[b] = (b <= msb) ? sh[b] : fill;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder.sv
// Data-memory target: wait-state FSM in front of a byte-writable SRAM.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          XLEN      = 64,
   parameter int          MEM_DEPTH = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          LATENCY   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic            mem_read_req,
   input  logic            mem_write_req,
   input  logic [2:0]      mem_size,
   input  logic            mem_signed,
   output logic [XLEN-1:0] mem_rdata,
   output logic            mem_ready,
   output logic            mem_error
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [XLEN:0] BASE_X = {1'b0, BASE_ADDR[XLEN-1:0]};
   localparam logic [XLEN:0] LIMIT  =
      (XLEN+1)'(MEM_DEPTH) * (XLEN+1)'(NB);
   localparam logic [3:0]    LAT_Q  = 4'(LATENCY);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "dmem_responder: XLEN must be 32 or 64");
   end

   if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_lat
      $fatal(1, "dmem_responder: LATENCY must be 0..15");
   end

   logic [XLEN-1:0] mem [MEM_DEPTH];

   dmem_rsp_state_e state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      size_q, size_d;
   logic            sext_q, sext_d;
   logic            wr_q, wr_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic            error_q, error_d;

   logic            idle;
   logic [XLEN-1:0] addr_s;
   logic [XLEN-1:0] wdata_s;
   logic [2:0]      size_s;
   logic            sext_s;
   logic            wr_s;

   logic [XLEN:0]   off;
   logic            below;
   logic            above;
   logic            size_bad;
   logic            misal;
   logic            err_acc;
   logic            err_s;
   logic [IDXW-1:0] idx;
   logic [OFFW-1:0] lane;

   logic [NB-1:0]   strb;
   logic [XLEN-1:0] wrep;
   logic [XLEN-1:0] rext;
   logic [XLEN-1:0] rword;
   logic            commit;
   logic            we;

   // Live request while idle (zero-latency commit), latched one afterwards.
   always_comb begin
      idle    = (state_q == RSP_IDLE);
      addr_s  = idle ? mem_addr      : addr_q;
      wdata_s = idle ? mem_wdata     : wdata_q;
      size_s  = idle ? mem_size      : size_q;
      sext_s  = idle ? mem_signed    : sext_q;
      wr_s    = idle ? mem_write_req : wr_q;
   end

   // Address decode and fault classification; offset has a borrow bit.
   always_comb begin
      off      = {1'b0, addr_s} - BASE_X;
      below    = off[XLEN];
      above    = (off >= LIMIT);
      size_bad = (size_s > 3'd3) || (size_s == 3'd3 && XLEN == 32);
      err_acc  = (mem_read_req & mem_write_req) | size_bad | misal
               | below | above;
      err_s    = idle ? err_acc : err_q;
      lane     = addr_s[OFFW-1:0];
      idx      = off[OFFW +: IDXW];
      rword    = mem[idx];
   end

   dmem_lane_unit #(
      .XLEN (XLEN)
   ) u_lane (
      .lane  (lane),
      .size  (mem_size_e'(size_s[1:0])),
      .sext  (sext_s),
      .wdata (wdata_s),
      .rword (rword),
      .strb  (strb),
      .wrep  (wrep),
      .rext  (rext),
      .misal (misal)
   );

   // Next-state: accept, count wait states, commit on entry to RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      wr_d    = wr_q;
      err_d   = err_q;
      rdata_d = '0;
      ready_d = 1'b0;
      error_d = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         RSP_IDLE: begin
            if (mem_read_req | mem_write_req) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               size_d  = mem_size;
               sext_d  = mem_signed;
               wr_d    = mem_write_req;
               err_d   = err_acc;
               cnt_d   = '0;
               if (LATENCY == 0) begin
                  state_d = RSP_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = RSP_WAIT;
               end
            end
         end
         RSP_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LAT_Q) begin
               state_d = RSP_RESP;
               cnt_d   = '0;
               commit  = 1'b1;
            end
         end
         RSP_RESP: begin
            state_d = RSP_IDLE;
         end
         default: begin
            state_d = RSP_IDLE;
         end
      endcase
      if (commit) begin
         ready_d = 1'b1;
         error_d = err_s;
         if (!wr_s && !err_s) begin
            rdata_d = rext;
         end
      end
   end

   // A store lands only on a clean commit edge outside reset.
   assign we = commit & wr_s & ~err_s & ~reset;

   // Control and registered outputs; reset aborts any transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RSP_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         sext_q  <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   // Backing store with per-byte enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
               mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
         end
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;
   assign mem_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder.sv
// Randomized bench for dmem_responder at latencies 1, 3 and 0.
module tb_dmem_responder;

   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam int          DEPTH  = 4096;
   localparam int          NBYTES = DEPTH * 8;
   localparam int          LAT [3] = '{1, 3, 0};

   logic        clk = 1'b0;
   logic        reset [3];
   logic [63:0] addr  [3];
   logic [63:0] wdata [3];
   logic        rd    [3];
   logic        wr    [3];
   logic [2:0]  size  [3];
   logic        sgn   [3];
   logic [63:0] rdata [3];
   logic        ready [3];
   logic        error [3];

   logic [7:0]  mdl [3][NBYTES];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
         .XLEN      (64),
         .MEM_DEPTH (DEPTH),
         .BASE_ADDR (BASE),
         .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
      ) u_dut (
         .clk           (clk),
         .reset         (reset[g]),
         .mem_addr      (addr[g]),
         .mem_wdata     (wdata[g]),
         .mem_read_req  (rd[g]),
         .mem_write_req (wr[g]),
         .mem_size      (size[g]),
         .mem_signed    (sgn[g]),
         .mem_rdata     (rdata[g]),
         .mem_ready     (ready[g]),
         .mem_error     (error[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, fault rules, extension by arithmetic.
   function automatic void model(input int k, input bit r, input bit w,
                                 input logic [63:0] a, input logic [63:0] d,
                                 input logic [2:0] sz, input bit s,
                                 output bit e, output logic [63:0] v);
      longint unsigned n;
      longint unsigned off;
      e = 1'b0;
      v = '0;
      if (sz > 3) begin
         e = 1'b1;
      end else begin
         n = 64'd1 << sz;
         if (r && w) e = 1'b1;
         if (a % n != 0) e = 1'b1;
         if (a < BASE) e = 1'b1;
         else if (a - BASE >= NBYTES) e = 1'b1;
      end
      if (e) return;
      off = a - BASE;
      if (w) begin
         for (int i = 0; i < int'(n); i++) mdl[k][off+i] = d[8*i +: 8];
      end else begin
         for (int i = 0; i < int'(n); i++)
            v = v | (64'(mdl[k][off+i]) << (8 * i));
         if (s && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
      end
   endfunction

   task automatic xfer(input int k, input bit r, input bit w,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] sz, input bit s,
                       output logic [63:0] rdo, output logic eo,
                       output int lat, output bit quiet);
      quiet = 1'b1;
      lat   = -1;
      rdo   = 'x;
      eo    = 1'bx;
      @(posedge clk); #1;
      addr[k]  = a;
      wdata[k] = d;
      size[k]  = sz;
      sgn[k]   = s;
      rd[k]    = r;
      wr[k]    = w;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (ready[k]) begin
            lat = c;
            rdo = rdata[k];
            eo  = error[k];
            break;
         end else if (rdata[k] != 0 || error[k]) begin
            quiet = 1'b0;
         end
      end
      rd[k] = 1'b0;
      wr[k] = 1'b0;
   endtask

   task automatic op(input int k, input string tag, input bit r,
                     input bit w, input logic [63:0] a,
                     input logic [63:0] d, input logic [2:0] sz,
                     input bit s);
      bit          ee;
      logic [63:0] ev;
      logic [63:0] gd;
      logic        ge;
      int          lat;
      bit          q;
      model(k, r, w, a, d, sz, s, ee, ev);
      xfer(k, r, w, a, d, sz, s, gd, ge, lat, q);
      check({tag, ".lat"}, 64'(lat), 64'(1 + LAT[k]));
      check({tag, ".err"}, 64'(ge), 64'(ee));
      check({tag, ".rdata"}, gd, ev);
      check({tag, ".quiet"}, 64'(q), 64'd1);
   endtask

   initial begin
      bit          ee;
      logic [63:0] ev;
      int          pulses;
      int          first;
      bit          r;
      bit          w;
      logic [63:0] a;
      logic [2:0]  sz;

      for (int k = 0; k < 3; k++) begin
         reset[k] = 1'b1;
         addr[k]  = '0;
         wdata[k] = '0;
         rd[k]    = 1'b0;
         wr[k]    = 1'b0;
         size[k]  = '0;
         sgn[k]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst%0d.ready", k), 64'(ready[k]), 64'd0);
         check($sformatf("rst%0d.error", k), 64'(error[k]), 64'd0);
         check($sformatf("rst%0d.rdata", k), rdata[k], 64'd0);
         reset[k] = 1'b0;
      end

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 16; i++)
            op(k, "init", 0, 1, BASE + 64'(8 * i),
               {$urandom, $urandom}, 3'd3, 0);

      op(0, "sd", 0, 1, BASE + 64'h10, 64'h1122334455667788, 3'd3, 0);
      op(0, "ld", 1, 0, BASE + 64'h10, 64'h0, 3'd3, 0);
      op(0, "clr", 0, 1, BASE + 64'h10, 64'h0, 3'd3, 0);
      op(0, "sb", 0, 1, BASE + 64'h13, 64'hDEAD_BEEF_0000_00AB, 3'd0, 0);
      op(0, "lbu", 1, 0, BASE + 64'h13, 64'h0, 3'd0, 0);
      op(0, "lb", 1, 0, BASE + 64'h13, 64'h0, 3'd0, 1);
      op(0, "ld2", 1, 0, BASE + 64'h10, 64'h0, 3'd3, 0);
      op(0, "lw_mis", 1, 0, BASE + 64'h2, 64'h0, 3'd2, 0);
      op(0, "sh_mis", 0, 1, BASE + 64'h1, 64'hFFFF, 3'd1, 0);
      op(0, "ld_w0", 1, 0, BASE, 64'h0, 3'd3, 0);
      op(0, "ld_low", 1, 0, 64'h7FFF_FFF8, 64'h0, 3'd3, 0);
      op(0, "ld_end", 1, 0, BASE + 64'(NBYTES), 64'h0, 3'd3, 0);
      op(0, "ld_wrap", 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 3'd3, 0);
      op(0, "sz4", 1, 0, BASE, 64'h0, 3'd4, 0);
      op(0, "sd_last", 0, 1, BASE + 64'(NBYTES - 8), 64'hCAFE_F00D_1234_5678,
         3'd3, 0);
      op(0, "ld_last", 1, 0, BASE + 64'(NBYTES - 8), 64'h0, 3'd3, 0);
      op(0, "both", 1, 1, BASE + 64'h18, 64'h5555, 3'd3, 0);
      op(0, "ld_both", 1, 0, BASE + 64'h18, 64'h0, 3'd3, 0);

      // Request held across the response: one pulse at n+1+LATENCY.
      model(1, 1, 0, BASE + 64'h20, 64'h0, 3'd3, 0, ee, ev);
      @(posedge clk); #1;
      addr[1] = BASE + 64'h20;
      size[1] = 3'd3;
      sgn[1]  = 1'b0;
      rd[1]   = 1'b1;
      pulses  = 0;
      first   = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (ready[1]) begin
            pulses++;
            if (first < 0) begin
               first = c;
               check("hold.rdata", rdata[1], ev);
            end
         end
         if (c == 5) rd[1] = 1'b0;
      end
      check("hold.pulses", 64'(pulses), 64'd1);
      check("hold.first", 64'(first), 64'd4);

      // Reset during the wait states of a store drops it.
      op(1, "old", 0, 1, BASE + 64'h40, 64'h0123_4567_89AB_CDEF, 3'd3, 0);
      @(posedge clk); #1;
      addr[1]  = BASE + 64'h40;
      wdata[1] = 64'hFFFF_0000_FFFF_0000;
      size[1]  = 3'd3;
      wr[1]    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset[1] = 1'b1;
      wr[1]    = 1'b0;
      #1;
      check("abort.ready", 64'(ready[1]), 64'd0);
      check("abort.error", 64'(error[1]), 64'd0);
      check("abort.rdata", rdata[1], 64'd0);
      pulses = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) reset[1] = 1'b0;
         if (ready[1]) pulses++;
      end
      check("abort.pulses", 64'(pulses), 64'd0);
      op(1, "reread", 1, 0, BASE + 64'h40, 64'h0, 3'd3, 0);

      // Zero latency with the request held: ready every second cycle.
      model(2, 1, 0, BASE + 64'h28, 64'h0, 3'd3, 0, ee, ev);
      @(posedge clk); #1;
      addr[2] = BASE + 64'h28;
      size[2] = 3'd3;
      sgn[2]  = 1'b0;
      rd[2]   = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         check($sformatf("b2b.rdy%0d", c), 64'(ready[2]), 64'(c % 2));
         if (ready[2]) check($sformatf("b2b.data%0d", c), rdata[2], ev);
      end
      rd[2] = 1'b0;

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 40; i++) begin
            int p;
            p  = $urandom_range(0, 19);
            sz = 3'($urandom_range(0, 3));
            r  = (p < 9);
            w  = (p >= 9 && p < 18);
            a  = BASE + 64'(8 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0)
               a = a + 64'(((1 << sz) * $urandom_range(0, 7)) % 8);
            else
               a = a + 64'($urandom_range(0, 7));
            if (p == 18) begin
               r = 1'b1;
               w = 1'b1;
            end
            if (p == 19) begin
               r  = 1'b1;
               sz = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(4, 7))
                                               : sz;
               if (sz <= 3)
                  a = ($urandom_range(0, 1) != 0) ? BASE - 64'd8
                                                 : BASE + 64'(NBYTES);
            end
            op(k, $sformatf("rnd%0d_%0d", k, i), r, w, a,
               {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
